sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Multi-port front end for the SDRAM controller's internal interface (idle/acc/ack/we/adr/dat/sel). It lets NUM_PORTS independent masters (video scan-out, rasteriser, UART loader, test sequencer) share one `sdram_ctrl_wrapper` instance. It replaces the single hard-wired write/read sequencer in the ULX3S top. Arbitration is round-robin, with an optional high-priority port that is bounded by an anti-starvation limit.

## Interface
Parameters:
- NUM_PORTS, 4, number of master ports (2..8)
- ADDR_WIDTH, 32, address width per port and to controller
- DATA_WIDTH, 16, data width
- SEL_WIDTH, DATA_WIDTH/8, byte-select width
- PRIO_EN, 1, 1 = PRIO_PORT wins over round-robin; 0 = pure round-robin
- PRIO_PORT, 0, index of the priority port (video)
- MAX_PRIO_STREAK, 4, maximum consecutive priority grants while another port waits (1..15)

Ports:
- clk  in  1  single clock (the SDRAM clock)
- reset_n_i  in  1  asynchronous, active-low reset
- port_req_i  in  NUM_PORTS  per-port request level
- port_we_i  in  NUM_PORTS  per-port write enable
- port_adr_i  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- port_dat_i  in  NUM_PORTS*DATA_WIDTH  packed write data
- port_sel_i  in  NUM_PORTS*SEL_WIDTH  packed byte selects
- port_ack_o  out  NUM_PORTS  one-cycle completion pulse to the granted port
- port_dat_o  out  DATA_WIDTH  shared read data, valid while port_ack_o is set
- grant_o  out  NUM_PORTS  one-hot grant of the transaction in flight
- ctrl_idle_i  in  1  controller idle
- ctrl_acc_o  out  1  access request to controller
- ctrl_we_o  out  1  write enable to controller
- ctrl_adr_o  out  ADDR_WIDTH  address to controller
- ctrl_dat_o  out  DATA_WIDTH  write data to controller
- ctrl_sel_o  out  SEL_WIDTH  byte select to controller
- ctrl_ack_i  in  1  controller completion
- ctrl_dat_i  in  DATA_WIDTH  controller read data

## Operation
- Three states: IDLE, BUSY, RELEASE. All outputs are registered.
- **IDLE:** when ctrl_idle_i=1 and any port_req_i bit is set, pick a winner:
  - If PRIO_EN, port_req_i[PRIO_PORT] is set, and streak < MAX_PRIO_STREAK (or no other port is requesting), PRIO_PORT wins.
  - Otherwise the first requester in order last+1, last+2, … (mod NUM_PORTS) wins. Round-robin may select PRIO_PORT.
- **On a win:**
  - Latch the winner's we/adr/dat/sel into the ctrl_* registers.
  - Set ctrl_acc_o=1 and the grant_o one-hot bit; go to BUSY.
- **BUSY:** hold all ctrl_* outputs stable until ctrl_ack_i=1. Then:
  - ctrl_acc_o←0, ctrl_we_o←0.
  - port_ack_o[winner]←1 and port_dat_o←ctrl_dat_i (captured for writes too).
  - last←winner; go to RELEASE.
- **Streak counter** (4 bits) is updated on each ack:
  - priority win while another port was requesting at grant time: increment, saturating;
  - any other grant: clear.
- **RELEASE:** clear port_ack_o and grant_o; go to IDLE. No arbitration happens in RELEASE.
- **Port protocol:**
  - Hold req and fields stable until the ack pulse.
  - Drop req (registered) on the edge after the ack is seen, or keep it high to issue a back-to-back transaction.
- **Protocol violation:** a req dropped before its ack does not abort the transaction. The ack is still issued.
- **Reset (asynchronous, any state):**
  - State→IDLE, last←NUM_PORTS-1 (port 0 has first round-robin turn), streak←0.
  - All outputs 0: ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o, ctrl_sel_o, port_ack_o, port_dat_o, grant_o.
  - The controller shares this reset, so an in-flight access is abandoned.

## Timing
- Grant latency: the IDLE edge that sees req and ctrl_idle_i raises ctrl_acc_o (1 cycle from req visible).
- Completion: port_ack_o rises on the edge after ctrl_ack_i is sampled high, and lasts exactly 1 cycle.
- Turnaround: ack edge → RELEASE → IDLE. The next grant is possible at the earliest 2 edges after the ack edge, and needs ctrl_idle_i=1.
- A requester that drops req registered on its ack is not regranted (its req is low at the IDLE sample).
- Simultaneous requests: decided within the same IDLE cycle. Exactly one grant; the losers keep waiting without an ack.
- ctrl_idle_i=0 in IDLE: wait with no grant. The winner is re-evaluated every cycle, so a late-arriving higher-priority request can overtake.
- ctrl_ack_i outside BUSY: ignored.

## Test plan
- **Reset values:** assert reset_n_i=0 mid-BUSY → all outputs 0 immediately (async). Release reset with ports 0 and 2 requesting → port 0 granted first.
- **Round-robin:** PRIO_EN=0, ports 0–3 requesting continuously, controller acks 3 cycles after acc → grant order 0,1,2,3,0,…; each port_ack_o pulse is exactly 1 cycle.
- **Priority with anti-starvation:** PRIO_EN=1, MAX_PRIO_STREAK=4, ports 0 and 1 requesting continuously → grants 0,0,0,0,1,0,0,0,0,1.
- **Read data path:** port 2 reads adr 0x0000_1234, controller returns 0xBEEF with ack → port_dat_o=0xBEEF while port_ack_o=4'b0100.
- **Write data path:** port 3 writes adr 0x10, dat 0xF00A, sel 2'b01 → ctrl_adr_o/ctrl_dat_o/ctrl_sel_o/ctrl_we_o equal 0x10/0xF00A/2'b01/1, stable through all BUSY cycles.
- **Idle gating:** ctrl_idle_i held 0 for 10 cycles with port 1 requesting → ctrl_acc_o stays 0. ctrl_idle_i→1 → acc rises on the next edge; a spurious ctrl_ack_i pulse while in IDLE → no port_ack_o.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Purpose: bundles the master-port request/ack signals and the SDRAM
//          controller handshake of sdram_port_arbiter into one interface.
// Latency: none, wires only.
// Backpressure: none here; the arbiter's ack and the controller's idle/ack carry it.
//
// Signals:
//   port_req_i/we_i/adr_i/dat_i/sel_i   per-port request level and fields (packed, port k at k*W)
//   port_ack_o/port_dat_o/grant_o       per-port completion pulse, shared read data, one-hot grant
//   ctrl_idle_i/ack_i/dat_i             controller status and read data
//   ctrl_acc_o/we_o/adr_o/dat_o/sel_o   access request to the controller
// Modports: master = arbiter side, slave = environment (ports + controller).
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
    logic [NUM_PORTS-1:0]            port_req_i;
    logic [NUM_PORTS-1:0]            port_we_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] port_adr_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] port_dat_i;
    logic [NUM_PORTS*SEL_WIDTH-1:0]  port_sel_i;
    logic [NUM_PORTS-1:0]            port_ack_o;
    logic [DATA_WIDTH-1:0]           port_dat_o;
    logic [NUM_PORTS-1:0]            grant_o;

    logic                            ctrl_idle_i;
    logic                            ctrl_acc_o;
    logic                            ctrl_we_o;
    logic [ADDR_WIDTH-1:0]           ctrl_adr_o;
    logic [DATA_WIDTH-1:0]           ctrl_dat_o;
    logic [SEL_WIDTH-1:0]            ctrl_sel_o;
    logic                            ctrl_ack_i;
    logic [DATA_WIDTH-1:0]           ctrl_dat_i;

    modport master (
        input  port_req_i, port_we_i, port_adr_i, port_dat_i, port_sel_i,
        output port_ack_o, port_dat_o, grant_o,
        input  ctrl_idle_i, ctrl_ack_i, ctrl_dat_i,
        output ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o, ctrl_sel_o
    );

    modport slave (
        output port_req_i, port_we_i, port_adr_i, port_dat_i, port_sel_i,
        input  port_ack_o, port_dat_o, grant_o,
        output ctrl_idle_i, ctrl_ack_i, ctrl_dat_i,
        input  ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o, ctrl_sel_o
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Purpose: shares one SDRAM controller between NUM_PORTS masters, round-robin with optional bounded priority port.
// Latency: grant 1 edge after req+ctrl_idle_i seen in IDLE; port ack 1 edge after ctrl_ack_i; 2-edge turnaround.
// Backpressure: losers and all ports while ctrl_idle_i=0 just hold req; no request is dropped or queued.
//
// Ports:
//   clk        single clock (SDRAM clock)
//   reset_n_i  asynchronous active-low reset; clears state and every output
//   bus        sdram_port_arbiter_if.master: per-port req/fields/ack and controller handshake
module sdram_port_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int SEL_WIDTH       = DATA_WIDTH / 8,
    parameter int PRIO_EN         = 1,
    parameter int PRIO_PORT       = 0,
    parameter int MAX_PRIO_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    sdram_port_arbiter_if.master  bus
);
    localparam int                    IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0]      PRIO_IDX   = IDX_W'(PRIO_PORT);
    localparam logic [IDX_W-1:0]      LAST_RST   = IDX_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0]  PRIO_MASK  = NUM_PORTS'(1) << PRIO_PORT;
    localparam logic [3:0]            STREAK_MAX = 4'(MAX_PRIO_STREAK);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Per-port fields unpacked so the winner can be selected with a plain index.
    logic [ADDR_WIDTH-1:0] w_adr_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_dat_arr [NUM_PORTS];
    logic [SEL_WIDTH-1:0]  w_sel_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_adr_arr[g] = bus.port_adr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_dat_arr[g] = bus.port_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_sel_arr[g] = bus.port_sel_i[g*SEL_WIDTH +: SEL_WIDTH];
    end

    state_t                 r_state,      w_nxt_state;
    logic [IDX_W-1:0]       r_last,       w_nxt_last;
    logic [IDX_W-1:0]       r_winner,     w_nxt_winner;
    logic [3:0]             r_streak,     w_nxt_streak;
    logic                   r_contested,  w_nxt_contested;
    logic                   r_acc,        w_nxt_acc;
    logic                   r_we,         w_nxt_we;
    logic [ADDR_WIDTH-1:0]  r_adr,        w_nxt_adr;
    logic [DATA_WIDTH-1:0]  r_dat,        w_nxt_dat;
    logic [SEL_WIDTH-1:0]   r_sel,        w_nxt_sel;
    logic [NUM_PORTS-1:0]   r_port_ack,   w_nxt_port_ack;
    logic [DATA_WIDTH-1:0]  r_port_dat,   w_nxt_port_dat;
    logic [NUM_PORTS-1:0]   r_grant,      w_nxt_grant;

    logic                   w_any_req;
    logic                   w_others_req;
    logic                   w_prio_win;
    logic                   w_rr_found;
    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_rr_idx;
    logic [IDX_W-1:0]       w_win_idx;

    assign w_any_req    = |bus.port_req_i;
    assign w_others_req = |(bus.port_req_i & ~PRIO_MASK);

    // The priority port may only win MAX_PRIO_STREAK times in a row while
    // somebody else is waiting; with nobody else waiting it always wins.
    assign w_prio_win = (PRIO_EN != 0) && bus.port_req_i[PRIO_IDX] &&
                        ((r_streak < STREAK_MAX) || !w_others_req);

    // Round-robin search starting just after the last served port.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_last;
        w_cand     = r_last;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_cand = IDX_W'((int'(r_last) + i) % NUM_PORTS);
            if (!w_rr_found && bus.port_req_i[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    assign w_win_idx = w_prio_win ? PRIO_IDX : w_rr_idx;

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_last      = r_last;
        w_nxt_winner    = r_winner;
        w_nxt_streak    = r_streak;
        w_nxt_contested = r_contested;
        w_nxt_acc       = r_acc;
        w_nxt_we        = r_we;
        w_nxt_adr       = r_adr;
        w_nxt_dat       = r_dat;
        w_nxt_sel       = r_sel;
        w_nxt_port_ack  = r_port_ack;
        w_nxt_port_dat  = r_port_dat;
        w_nxt_grant     = r_grant;

        case (r_state)
            S_IDLE: begin
                // Arbitration is redone every IDLE cycle, so a request that
                // arrives while the controller is busy can still overtake.
                if (bus.ctrl_idle_i && w_any_req) begin
                    w_nxt_state     = S_BUSY;
                    w_nxt_winner    = w_win_idx;
                    w_nxt_contested = w_prio_win && w_others_req;
                    w_nxt_acc       = 1'b1;
                    w_nxt_we        = bus.port_we_i[w_win_idx];
                    w_nxt_adr       = w_adr_arr[w_win_idx];
                    w_nxt_dat       = w_dat_arr[w_win_idx];
                    w_nxt_sel       = w_sel_arr[w_win_idx];
                    w_nxt_grant     = NUM_PORTS'(1) << w_win_idx;
                end
            end
            S_BUSY: begin
                if (bus.ctrl_ack_i) begin
                    w_nxt_state    = S_RELEASE;
                    w_nxt_acc      = 1'b0;
                    w_nxt_we       = 1'b0;
                    w_nxt_port_ack = NUM_PORTS'(1) << r_winner;
                    w_nxt_port_dat = bus.ctrl_dat_i;
                    w_nxt_last     = r_winner;
                    if (r_contested)
                        w_nxt_streak = (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
                    else
                        w_nxt_streak = 4'd0;
                end
            end
            S_RELEASE: begin
                // One dead cycle lets a port drop its req after seeing the ack
                // before the next arbitration samples it.
                w_nxt_state    = S_IDLE;
                w_nxt_port_ack = '0;
                w_nxt_grant    = '0;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_last      <= LAST_RST;
            r_winner    <= '0;
            r_streak    <= 4'd0;
            r_contested <= 1'b0;
            r_acc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_port_ack  <= '0;
            r_port_dat  <= '0;
            r_grant     <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_last      <= w_nxt_last;
            r_winner    <= w_nxt_winner;
            r_streak    <= w_nxt_streak;
            r_contested <= w_nxt_contested;
            r_acc       <= w_nxt_acc;
            r_we        <= w_nxt_we;
            r_adr       <= w_nxt_adr;
            r_dat       <= w_nxt_dat;
            r_sel       <= w_nxt_sel;
            r_port_ack  <= w_nxt_port_ack;
            r_port_dat  <= w_nxt_port_dat;
            r_grant     <= w_nxt_grant;
        end
    end

    assign bus.ctrl_acc_o = r_acc;
    assign bus.ctrl_we_o  = r_we;
    assign bus.ctrl_adr_o = r_adr;
    assign bus.ctrl_dat_o = r_dat;
    assign bus.ctrl_sel_o = r_sel;
    assign bus.port_ack_o = r_port_ack;
    assign bus.port_dat_o = r_port_dat;
    assign bus.grant_o    = r_grant;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a pure round-robin instance (u_rr) and a
// priority instance (u_pr) with a small controller model each.
// Expected acks are queued when requests are driven and popped by a monitor.
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .SEL_WIDTH(2)) bus_rr ();
    sdram_port_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .SEL_WIDTH(2)) bus_pr ();

    sdram_port_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .SEL_WIDTH(2),
                         .PRIO_EN(0), .PRIO_PORT(0), .MAX_PRIO_STREAK(4))
        u_rr (.clk(clk), .reset_n_i(rst_n), .bus(bus_rr));

    sdram_port_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .SEL_WIDTH(2),
                         .PRIO_EN(1), .PRIO_PORT(0), .MAX_PRIO_STREAK(4))
        u_pr (.clk(clk), .reset_n_i(rst_n), .bus(bus_pr));

    // ---------------- stimulus side signals ----------------
    logic [31:0] adr_rr [4];
    logic [15:0] dat_rr [4];
    logic [1:0]  sel_rr [4];
    logic [3:0]  we_rr;
    logic        auto_rr, man_ack_rr, mdl_ack_rr;
    logic        mdl_ack_pr;
    int          cnt_rr, cnt_pr;

    assign bus_rr.port_adr_i = {adr_rr[3], adr_rr[2], adr_rr[1], adr_rr[0]};
    assign bus_rr.port_dat_i = {dat_rr[3], dat_rr[2], dat_rr[1], dat_rr[0]};
    assign bus_rr.port_sel_i = {sel_rr[3], sel_rr[2], sel_rr[1], sel_rr[0]};
    assign bus_rr.port_we_i  = we_rr;
    assign bus_rr.ctrl_ack_i = auto_rr ? mdl_ack_rr : man_ack_rr;

    assign bus_pr.port_we_i   = '0;
    assign bus_pr.port_adr_i  = '0;
    assign bus_pr.port_dat_i  = '0;
    assign bus_pr.port_sel_i  = '0;
    assign bus_pr.ctrl_idle_i = 1'b1;
    assign bus_pr.ctrl_dat_i  = '0;
    assign bus_pr.ctrl_ack_i  = mdl_ack_pr;

    // Controller model: ack on the third cycle after acc is seen high.
    initial begin
        mdl_ack_rr = 1'b0; mdl_ack_pr = 1'b0; cnt_rr = 0; cnt_pr = 0;
        forever begin
            @(posedge clk); #1;
            if (!auto_rr || !bus_rr.ctrl_acc_o || mdl_ack_rr) begin
                mdl_ack_rr = 1'b0; cnt_rr = 0;
            end else begin
                cnt_rr++;
                if (cnt_rr == 3) mdl_ack_rr = 1'b1;
            end
            if (!bus_pr.ctrl_acc_o || mdl_ack_pr) begin
                mdl_ack_pr = 1'b0; cnt_pr = 0;
            end else begin
                cnt_pr++;
                if (cnt_pr == 3) mdl_ack_pr = 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [3:0]  ack;
        logic [15:0] dat;
    } exp_t;

    exp_t exp_rr [$];
    exp_t exp_pr [$];
    exp_t e_rr, e_pr;
    logic [3:0] prev_ack_rr = '0;
    logic [3:0] prev_ack_pr = '0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (prev_ack_rr != 0)
                check("rr_ack_one_cycle", bus_rr.port_ack_o, 4'b0);
            else if (bus_rr.port_ack_o != 0) begin
                if (exp_rr.size() == 0)
                    check("rr_unexpected_ack", bus_rr.port_ack_o, 4'b0);
                else begin
                    e_rr = exp_rr.pop_front();
                    check("rr_ack_grant", {bus_rr.port_ack_o, bus_rr.grant_o}, {e_rr.ack, e_rr.ack});
                    check("rr_port_dat", bus_rr.port_dat_o, e_rr.dat);
                end
            end
            prev_ack_rr = bus_rr.port_ack_o;
        end else prev_ack_rr = '0;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (prev_ack_pr != 0)
                check("pr_ack_one_cycle", bus_pr.port_ack_o, 4'b0);
            else if (bus_pr.port_ack_o != 0) begin
                if (exp_pr.size() == 0)
                    check("pr_unexpected_ack", bus_pr.port_ack_o, 4'b0);
                else begin
                    e_pr = exp_pr.pop_front();
                    check("pr_ack_grant", {bus_pr.port_ack_o, bus_pr.grant_o}, {e_pr.ack, e_pr.ack});
                end
            end
            prev_ack_pr = bus_pr.port_ack_o;
        end else prev_ack_pr = '0;
    end

    task automatic wait_acc_rr(input string name);
        int n = 0;
        while (bus_rr.ctrl_acc_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check(name, bus_rr.ctrl_acc_o, 1'b1);
    endtask

    task automatic drain_rr(input string name);
        int n = 0;
        while (exp_rr.size() != 0 && n < 400) begin @(negedge clk); n++; end
        check(name, exp_rr.size(), 0);
        bus_rr.port_req_i = '0;
    endtask

    task automatic drain_pr(input string name);
        int n = 0;
        while (exp_pr.size() != 0 && n < 400) begin @(negedge clk); n++; end
        check(name, exp_pr.size(), 0);
        bus_pr.port_req_i = '0;
    endtask

    function automatic logic [75:0] all_out_rr();
        return {bus_rr.ctrl_acc_o, bus_rr.ctrl_we_o, bus_rr.ctrl_adr_o, bus_rr.ctrl_dat_o,
                bus_rr.ctrl_sel_o, bus_rr.port_ack_o, bus_rr.port_dat_o, bus_rr.grant_o};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [31:0] adr;
        logic [15:0] wdat;
        logic [1:0]  sel;
        logic [15:0] rdat;
        logic        exp_we;
        logic [31:0] exp_adr;
        logic [15:0] exp_dat;
        logic [1:0]  exp_sel;
        logic [3:0]  exp_ack;
        logic [15:0] exp_pdat;
    } vec_t;

    vec_t vecs [4];
    vec_t cur;
    logic viol, spur;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd2, 1'b0, 32'h0000_1234, 16'h7777, 2'b11, 16'hBEEF,
                    1'b0, 32'h0000_1234, 16'h7777, 2'b11, 4'b0100, 16'hBEEF};
        vecs[1] = '{2'd0, 1'b1, 32'hDEAD_0000, 16'h1234, 2'b11, 16'h0000,
                    1'b1, 32'hDEAD_0000, 16'h1234, 2'b11, 4'b0001, 16'h0000};
        vecs[2] = '{2'd1, 1'b0, 32'hFFFF_FFFE, 16'h0000, 2'b10, 16'hA5A5,
                    1'b0, 32'hFFFF_FFFE, 16'h0000, 2'b10, 4'b0010, 16'hA5A5};
        vecs[3] = '{2'd3, 1'b1, 32'h0000_0010, 16'hF00A, 2'b01, 16'h5555,
                    1'b1, 32'h0000_0010, 16'hF00A, 2'b01, 4'b1000, 16'h5555};

        rst_n = 1'b1;
        adr_rr = '{32'h0, 32'h0, 32'h0, 32'h0};
        dat_rr = '{16'h0, 16'h0, 16'h0, 16'h0};
        sel_rr = '{2'b0, 2'b0, 2'b0, 2'b0};
        we_rr = '0;
        auto_rr = 1'b1; man_ack_rr = 1'b0;
        bus_rr.port_req_i = '0; bus_rr.ctrl_idle_i = 1'b1; bus_rr.ctrl_dat_i = '0;
        bus_pr.port_req_i = '0;
        #1 rst_n = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset_rr_outputs", all_out_rr(), 76'b0);
        check("reset_pr_outputs", {bus_pr.ctrl_acc_o, bus_pr.port_ack_o, bus_pr.grant_o}, 9'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transactions from the table.
        for (int i = 0; i < 4; i++) begin
            cur = vecs[i];
            we_rr[cur.port]  = cur.we;
            adr_rr[cur.port] = cur.adr;
            dat_rr[cur.port] = cur.wdat;
            sel_rr[cur.port] = cur.sel;
            bus_rr.ctrl_dat_i = cur.rdat;
            exp_rr.push_back('{ack: cur.exp_ack, dat: cur.exp_pdat});
            bus_rr.port_req_i = 4'b0001 << cur.port;
            wait_acc_rr("vec_grant_timeout");
            check("vec_grant", bus_rr.grant_o, cur.exp_ack);
            for (int n = 0; n < 20 && bus_rr.ctrl_acc_o; n++) begin
                check("vec_ctrl_hold",
                      {bus_rr.ctrl_we_o, bus_rr.ctrl_adr_o, bus_rr.ctrl_dat_o, bus_rr.ctrl_sel_o},
                      {cur.exp_we, cur.exp_adr, cur.exp_dat, cur.exp_sel});
                @(negedge clk);
            end
            check("vec_acc_release", {bus_rr.ctrl_acc_o, bus_rr.ctrl_we_o}, 2'b00);
            @(posedge clk); #1;
            bus_rr.port_req_i = '0;
            repeat (4) @(negedge clk);
            check("vec_no_regrant", bus_rr.ctrl_acc_o, 1'b0);
        end

        // Round-robin with all ports requesting; last served was port 3.
        adr_rr = '{32'h100, 32'h101, 32'h102, 32'h103};
        bus_rr.ctrl_dat_i = 16'h0C0C;
        for (int r = 0; r < 2; r++) begin
            exp_rr.push_back('{ack: 4'b0001, dat: 16'h0C0C});
            exp_rr.push_back('{ack: 4'b0010, dat: 16'h0C0C});
            exp_rr.push_back('{ack: 4'b0100, dat: 16'h0C0C});
            exp_rr.push_back('{ack: 4'b1000, dat: 16'h0C0C});
        end
        bus_rr.port_req_i = 4'b1111;
        drain_rr("rr_order_drain");
        repeat (5) @(negedge clk);
        check("rr_quiet", bus_rr.ctrl_acc_o, 1'b0);

        // Priority port 0 against port 1: four priority wins, then one for port 1.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp_pr.push_back('{ack: 4'b0001, dat: 16'h0});
            exp_pr.push_back('{ack: 4'b0010, dat: 16'h0});
        end
        bus_pr.port_req_i = 4'b0011;
        drain_pr("pr_order_drain");
        repeat (5) @(negedge clk);
        check("pr_quiet", bus_pr.ctrl_acc_o, 1'b0);

        // Idle gating plus a spurious controller ack while in IDLE.
        auto_rr = 1'b0;
        bus_rr.ctrl_idle_i = 1'b0;
        adr_rr[1] = 32'h20; we_rr[1] = 1'b0;
        bus_rr.ctrl_dat_i = 16'h1357;
        bus_rr.port_req_i = 4'b0010;
        viol = 1'b0; spur = 1'b0;
        for (int n = 0; n < 10; n++) begin
            man_ack_rr = (n == 4);
            @(negedge clk);
            viol = viol | bus_rr.ctrl_acc_o;
            spur = spur | (bus_rr.port_ack_o != 0);
        end
        man_ack_rr = 1'b0;
        check("idle_gate_no_acc", viol, 1'b0);
        check("idle_spurious_ack", spur, 1'b0);
        bus_rr.ctrl_idle_i = 1'b1;
        @(negedge clk);
        check("idle_release_acc", {bus_rr.ctrl_acc_o, bus_rr.grant_o}, {1'b1, 4'b0010});
        exp_rr.push_back('{ack: 4'b0010, dat: 16'h1357});
        repeat (2) @(negedge clk);
        man_ack_rr = 1'b1;
        @(negedge clk);
        man_ack_rr = 1'b0;
        @(posedge clk); #1;
        bus_rr.port_req_i = '0;
        drain_rr("idle_drain");

        // Asynchronous reset in the middle of BUSY.
        adr_rr[1] = 32'hABCD_0001;
        bus_rr.port_req_i = 4'b0010;
        wait_acc_rr("rst_busy_timeout");
        @(negedge clk);
        check("rst_busy_pre", bus_rr.grant_o, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", all_out_rr(), 76'b0);
        bus_rr.port_req_i = 4'b0101;
        bus_rr.ctrl_dat_i = 16'h2468;
        auto_rr = 1'b1;
        exp_rr.push_back('{ack: 4'b0001, dat: 16'h2468});
        exp_rr.push_back('{ack: 4'b0100, dat: 16'h2468});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_acc_rr("rst_regrant_timeout");
        check("rst_first_grant", bus_rr.grant_o, 4'b0001);
        drain_rr("rst_drain");
        repeat (5) @(negedge clk);
        check("final_quiet", {bus_rr.ctrl_acc_o, bus_pr.ctrl_acc_o}, 2'b00);
        check("final_queues", exp_rr.size() + exp_pr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
